// File: rtl/alsu_if.sv
// Operand/control bundle into the pipelined ALSU and the result bus out of it.
// The master drives operands and controls; the slave (the ALSU) drives results.
interface alsu_if #(
    parameter int WIDTH     = 8,
    parameter int LED_WIDTH = 16
) ();
    logic                   in_valid;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2:0]             opcode;
    logic                   cin;
    logic                   serial_in;
    logic                   direction;
    logic                   red_op_A;
    logic                   red_op_B;
    logic                   bypass_A;
    logic                   bypass_B;
    logic [2*WIDTH-1:0]     out;
    logic                   out_valid;
    logic                   err;
    logic [LED_WIDTH-1:0]   leds;

    modport master (
        output in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        input  out, out_valid, err, leds
    );

    modport slave (
        input  in_valid, A, B, opcode, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B,
        output out, out_valid, err, leds
    );
endinterface

// File: rtl/alsu_pipe.sv
// Two-stage pipelined ALSU: stage 1 registers operands/controls, stage 2
// computes the registered result, error flag and the error LED blink.
// SHIFT/ROTATE operate on the current result register, so a shift issued
// right behind another op uses that op's result without a bubble.
module alsu_pipe #(
    parameter int    WIDTH          = 8,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_WIDTH      = 16,
    parameter int    BLINK_DIV      = 4
) (
    input  logic   clk,
    input  logic   rst,
    alsu_if.slave  bus
);
    localparam int OUT_W = 2 * WIDTH;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam bit PRIO_A = (INPUT_PRIORITY == "A");
    localparam bit FA_ON  = (FULL_ADDER == "ON");

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MUL    = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              opcode;
        logic             cin;
        logic             serial_in;
        logic             direction;
        logic             red_a;
        logic             red_b;
        logic             byp_a;
        logic             byp_b;
    } s1_t;

    s1_t                  s1_d, s1_q;
    logic                 s1_valid_q;
    logic [OUT_W-1:0]     out_d, out_q;
    logic                 err_d, err_q;
    logic                 out_valid_q;
    logic [LED_WIDTH-1:0] leds_d, leds_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic                 invalid;
    logic                 red_bit;
    logic [WIDTH:0]       sum;

    assign s1_d = '{a:         bus.A,
                    b:         bus.B,
                    opcode:    op_e'(bus.opcode),
                    cin:       bus.cin,
                    serial_in: bus.serial_in,
                    direction: bus.direction,
                    red_a:     bus.red_op_A,
                    red_b:     bus.red_op_B,
                    byp_a:     bus.bypass_A,
                    byp_b:     bus.bypass_B};

    // Stage 1: capture operands on in_valid, otherwise hold them.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with <= so every register samples pre-edge values.
        if (rst) begin
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    assign invalid = (s1_q.opcode == OP_INV6) || (s1_q.opcode == OP_INV7) ||
                     ((s1_q.red_a || s1_q.red_b) &&
                      (s1_q.opcode != OP_AND) && (s1_q.opcode != OP_XOR));

    assign sum = {1'b0, s1_q.a} + {1'b0, s1_q.b} + (WIDTH+1)'(s1_q.cin & FA_ON);

    // Stage 2 next state: bypass beats invalid, invalid beats the opcode.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        out_d   = out_q;
        err_d   = err_q;
        red_bit = 1'b0;
        if (s1_valid_q) begin
            if (s1_q.byp_a || s1_q.byp_b) begin
                err_d = 1'b0;
                if (s1_q.byp_a && (!s1_q.byp_b || PRIO_A)) begin
                    out_d = {{WIDTH{1'b0}}, s1_q.a};
                end else begin
                    out_d = {{WIDTH{1'b0}}, s1_q.b};
                end
            end else if (invalid) begin
                out_d = '0;
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
                unique case (s1_q.opcode)
                    OP_AND, OP_XOR: begin
                        if (s1_q.red_a && (!s1_q.red_b || PRIO_A)) begin
                            red_bit = (s1_q.opcode == OP_AND) ? &s1_q.a : ^s1_q.a;
                            out_d   = {{(OUT_W-1){1'b0}}, red_bit};
                        end else if (s1_q.red_b) begin
                            red_bit = (s1_q.opcode == OP_AND) ? &s1_q.b : ^s1_q.b;
                            out_d   = {{(OUT_W-1){1'b0}}, red_bit};
                        end else if (s1_q.opcode == OP_AND) begin
                            out_d = {{WIDTH{1'b0}}, s1_q.a & s1_q.b};
                        end else begin
                            out_d = {{WIDTH{1'b0}}, s1_q.a ^ s1_q.b};
                        end
                    end
                    OP_ADD:    out_d = OUT_W'(sum);
                    OP_MUL:    out_d = OUT_W'(s1_q.a) * OUT_W'(s1_q.b);
                    OP_SHIFT:  out_d = s1_q.direction ? {out_q[OUT_W-2:0], s1_q.serial_in}
                                                      : {s1_q.serial_in, out_q[OUT_W-1:1]};
                    OP_ROTATE: out_d = s1_q.direction ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                                      : {out_q[0], out_q[OUT_W-1:1]};
                    default:   out_d = '0;
                endcase
            end
        end
    end

    // LED blink next state: all-ones on entering error, toggle every BLINK_DIV clocks.
    always_comb begin
        leds_d = leds_q;
        cnt_d  = cnt_q;
        if (!err_d) begin
            leds_d = '0;
            cnt_d  = '0;
        end else if (!err_q) begin
            leds_d = '1;
            cnt_d  = '0;
        end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
            leds_d = ~leds_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Stage 2 registers: result, error, valid strobe and blink state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here is reset so a mid-operation reset flushes the pipe.
        if (rst) begin
            out_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            leds_q      <= '0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            err_q       <= err_d;
            out_valid_q <= s1_valid_q;
            leds_q      <= leds_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.err       = err_q;
    assign bus.leds      = leds_q;
endmodule
